// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral-window bus initiator.
// Holds the register map, the FSM encoding and the queued command format.
package periph_bus_pkg;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic logic is_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and occupancy count.
// A push while full is refused even when a pop happens in the same cycle.
module cmd_fifo
  import periph_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  cmd_t                   i_data,
  input  logic                   i_pop,
  output cmd_t                   o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/periph_bus_master.sv
// Bus initiator for the 0x4000_0000 peripheral window: queued commands become
// single-beat rd/wr strobes, each returning one response.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // rsp_valid and its payload stay constant until that transfer.
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rd,
  output logic                 wr,
  output logic [31:0]          addr,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  input  logic                 en,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy,
  output state_e               dbg_state
);

  state_e                 r_state;
  state_e                 w_next;
  logic                   w_pop;
  cmd_t                   w_cmd_in;
  cmd_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(CMD_DEPTH):0] w_count;

  logic                   r_rd;
  logic                   r_wr;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic                   r_is_wr;
  logic                   r_misaligned;
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_rdata;
  logic                   r_rsp_err;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic                   w_rsp_err;
  logic [31:0]            w_rsp_rdata;

  assign w_cmd_in = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};

  cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_pop  = !w_empty;
          w_next = w_empty ? ST_IDLE : ST_ISSUE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Responder return pins are only meaningful while the ISSUE strobe is up.
  always_comb begin
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    if (r_misaligned) begin
      w_rsp_err = 1'b1;
    end else if (!r_is_wr) begin
      if (en) w_rsp_rdata = rdata;
      else    w_rsp_err   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_wr      <= 1'b0;
      r_misaligned <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_rd         <= !w_head.wr && is_aligned(w_head.addr);
        r_wr         <= w_head.wr && is_aligned(w_head.addr);
        r_addr       <= w_head.addr;
        r_wdata      <= w_head.wdata;
        r_is_wr      <= w_head.wr;
        r_misaligned <= !is_aligned(w_head.addr);
      end else begin
        r_rd    <= 1'b0;
        r_wr    <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
      end
      if (r_state == ST_ISSUE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rsp_rdata;
        r_rsp_err   <= w_rsp_err;
        if (w_rsp_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign err_count = r_err_count;
  assign busy      = (w_count != '0) || (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master with a register-file responder
// model and an in-order response scoreboard.
module tb_periph_bus_master;
  import periph_bus_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int ERR_CNT_W = 8;
  localparam logic [31:0] SW_VAL = 32'h0000_003C;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr;
  logic [31:0]          cmd_addr;
  logic [31:0]          cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 rd;
  logic                 wr;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 en;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;
  state_e               dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int exp_err = 0;
  logic [32:0] exp_q[$];
  int hs_q[$];
  logic [31:0] pregs [6] = '{default: '0};
  logic [31:0] ref_regs [6] = '{default: '0};

  periph_bus_master #(.CMD_DEPTH(CMD_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .en(en),
    .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic map_hit(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= ADDR_TH) && (a <= ADDR_DIGI);
  endfunction

  function automatic int map_idx(input logic [31:0] a);
    return int'((a - ADDR_TH) >> 2);
  endfunction

  // peripheral responder: switch is read-only, the rest are plain registers
  always_comb begin
    en    = 1'b0;
    rdata = 32'hDEAD_BEEF;
    if (rd && map_hit(addr)) begin
      en    = 1'b1;
      rdata = (map_idx(addr) == 4) ? SW_VAL : pregs[map_idx(addr)];
    end
  end

  always @(posedge clk) begin
    if (wr && map_hit(addr) && (map_idx(addr) != 4)) pregs[map_idx(addr)] <= wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model: returns {rdata, err} and tracks register contents in order
  function automatic logic [32:0] model_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] != 2'b00) return {32'h0, 1'b1};
    if (w) begin
      if (map_hit(a) && (map_idx(a) != 4)) ref_regs[map_idx(a)] = d;
      return 33'h0;
    end
    if (!map_hit(a)) return {32'h0, 1'b1};
    return {((map_idx(a) == 4) ? SW_VAL : ref_regs[map_idx(a)]), 1'b0};
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int guard = 0;
    logic [32:0] e;
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && guard < 200) begin tick(1); guard++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      e = model_cmd(w, a, d);
      exp_q.push_back(e);
      if (e[0]) exp_err++;
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid();
    int g = 0;
    while (!rsp_valid && g < 100) begin tick(1); g++; end
    check("wait_rsp_valid", rsp_valid, 1);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && g < 500) begin tick(1); g++; end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (rd || wr) check("strobe_excl", rd & wr, 0);
      if (rd) rd_cnt++;
      if (wr) wr_cnt++;
      if (rsp_valid && rsp_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[32:1]);
          check("rsp_err", rsp_err, e[0]);
        end
      end
    end
  end

  initial begin
    int r0, w0;
    bit rand_on;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    tick(3);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_wr", {rd, wr}, 0);
    check("rst_addr", addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(1);

    // write LED
    w0 = wr_cnt;
    send_cmd(1'b1, ADDR_LED, 32'h0000_00A5);
    check("wr_before", wr, 0);
    tick(1);
    check("wr_issue", wr, 1);
    check("wr_issue_rd", rd, 0);
    check("wr_issue_addr", addr, ADDR_LED);
    check("wr_issue_wdata", wdata, 32'hA5);
    tick(1);
    check("wr_drop", wr, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    tick(2);
    check("wr_pulses", wr_cnt - w0, 1);
    check("led_model", pregs[3], 32'hA5);

    // read switch, latency 2 edges
    r0 = rd_cnt;
    send_cmd(1'b0, ADDR_SWITCH, 32'h0);
    check("rd_before", rd, 0);
    tick(1);
    check("rd_issue", rd, 1);
    check("rd_issue_addr", addr, ADDR_SWITCH);
    tick(1);
    check("rd_drop", rd, 0);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h3C);
    check("rd_rsp_err", rsp_err, 0);
    tick(2);
    check("rd_pulses", rd_cnt - r0, 1);
    send_cmd(1'b0, ADDR_LED, 32'h0);
    drain();

    // unmapped and misaligned
    send_cmd(1'b0, 32'h4000_0020, 32'h0);
    drain();
    check("err_count_unmapped", err_count, 1);
    r0 = rd_cnt; w0 = wr_cnt;
    send_cmd(1'b0, 32'h4000_0006, 32'h0);
    drain();
    check("misaligned_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    check("err_count_misaligned", err_count, 2);

    // fill the FIFO behind a held response, then release
    rsp_ready = 1'b0;
    send_cmd(1'b0, ADDR_SWITCH, 32'h0);
    wait_rsp_valid();
    send_cmd(1'b1, ADDR_TH, 32'h100);
    send_cmd(1'b1, ADDR_TL, 32'h101);
    send_cmd(1'b1, ADDR_TCON, 32'h102);
    send_cmd(1'b1, ADDR_TH, 32'h103);
    check("full_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = ADDR_TH;
    tick(3);
    check("full_ready_hold", cmd_ready, 0);
    hs_q.delete();
    rsp_ready = 1'b1;
    send_cmd(1'b0, ADDR_TH, 32'h0);
    drain();
    check("burst_rsp_count", hs_q.size(), 6);
    for (int i = 1; i < hs_q.size(); i++) check("burst_spacing", hs_q[i] - hs_q[i-1], 2);

    // hold a response for 10 cycles
    rsp_ready = 1'b0;
    send_cmd(1'b0, ADDR_SWITCH, 32'h0);
    wait_rsp_valid();
    send_cmd(1'b1, ADDR_DIGI, 32'h7);
    r0 = rd_cnt; w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, SW_VAL);
      check("hold_err", rsp_err, 0);
      tick(1);
    end
    check("hold_no_strobe", (rd_cnt - r0) + (wr_cnt - w0), 0);
    rsp_ready = 1'b1;
    tick(1);
    check("next_issue_wr", wr, 1);
    check("next_issue_addr", addr, ADDR_DIGI);
    drain();
    check("digi_model", pregs[5], 32'h7);

    // reset mid-transaction
    rsp_ready = 1'b0;
    send_cmd(1'b0, ADDR_LED, 32'h0);
    wait_rsp_valid();
    send_cmd(1'b0, ADDR_SWITCH, 32'h0);
    send_cmd(1'b0, ADDR_TL, 32'h0);
    send_cmd(1'b0, ADDR_TCON, 32'h0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("pre_reset_rd", rd, 1);
    reset = 1'b1;
    #1;
    check("reset_rd_drop", rd, 0);
    exp_q.delete();
    exp_err = 0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post_reset_busy", busy, 0);
    check("post_reset_rsp_valid", rsp_valid, 0);
    check("post_reset_err_count", err_count, 0);
    check("post_reset_cmd_ready", cmd_ready, 1);

    // random traffic with random response back-pressure
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [31:0] a;
          case ($urandom_range(0, 7))
            0: a = ADDR_TH;
            1: a = ADDR_TL;
            2: a = ADDR_TCON;
            3: a = ADDR_LED;
            4: a = ADDR_SWITCH;
            5: a = ADDR_DIGI;
            6: a = 32'h4000_0040;
            default: a = ADDR_TL + 32'($urandom_range(1, 3));
          endcase
          send_cmd(1'($urandom_range(0, 1)), a, $urandom);
          if ($urandom_range(0, 3) == 0) tick(1);
        end
        rand_on = 1'b0;
      end
      begin
        for (int k = 0; k < 2000 && rand_on; k++) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    check("rand_err_count", err_count, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
